// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter, receiver and baud generator.
// Holds FSM state encodings, the oversampling factor and the accumulator sizing helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Wide enough to hold acc + increment before the wrap subtraction.
    function automatic int acc_width(input int clk_hz, input int baud);
        return $clog2(clk_hz + OVERSAMPLE * baud) + 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional phase-accumulator generating a 16x-oversample tick with no long-term drift.
// Latency: tick16_o is registered, one cycle after the wrap is detected.
// Backpressure: none, free-running.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 68000000,
    parameter int BAUD   = 115200
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    output logic tick16_o
);

    localparam int             W   = acc_width(CLK_HZ, BAUD);
    localparam logic [W-1:0]   INC = W'(OVERSAMPLE * BAUD);
    localparam logic [W-1:0]   LIM = W'(CLK_HZ);

    logic [W-1:0] r_acc;
    logic         r_tick;
    logic [W-1:0] w_sum;

    assign w_sum = r_acc + INC;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else if (w_sum >= LIM) begin
            r_acc  <= w_sum - LIM;
            r_tick <= 1'b1;
        end else begin
            r_acc  <= w_sum;
            r_tick <= 1'b0;
        end
    end

    assign tick16_o = r_tick;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART, parametrised width/stop bits; even parity when UART_PARITY_EN is defined.
// Latency: TX line falls 1 cycle after accept; rx_valid_o 1 cycle after first stop-bit mid-sample.
// Backpressure: tx_wr_i ignored while tx_busy_o is high; RX has none, each frame overwrites rx_dat_o.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 68000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    input  logic                 tx_wr_i,
    input  logic [DATA_BITS-1:0] tx_dat_i,
    output logic                 tx_busy_o,
    output logic                 uart_tx_o,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] rx_dat_o,
    output logic                 rx_valid_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_parity_err_o
);

    logic w_tick;

    uart_baud_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baud_gen (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .tick16_o  (w_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state;
    logic [3:0]           r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_line;
    logic                 r_tx_busy;
    logic                 w_tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 r_tx_par;
`endif

    assign w_tx_bit_end = w_tick && (r_tx_cnt == 4'd15);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else if (r_tx_state == TX_IDLE) begin
            if (tx_wr_i) begin
                r_tx_shift <= tx_dat_i;
                r_tx_line  <= 1'b0;
                r_tx_busy  <= 1'b1;
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
                r_tx_state <= TX_START;
`ifdef UART_PARITY_EN
                r_tx_par   <= ^tx_dat_i;
`endif
            end
        end else begin
            if (w_tick) r_tx_cnt <= r_tx_cnt + 4'd1;
            if (w_tx_bit_end) begin
                case (r_tx_state)
                    TX_START: begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (r_tx_bit == 4'(DATA_BITS - 1)) begin
                            r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
                            r_tx_line  <= r_tx_par;
                            r_tx_state <= TX_PARITY;
`else
                            r_tx_line  <= 1'b1;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 4'd1;
                        end
                    end
                    TX_PARITY: begin
                        r_tx_line  <= 1'b1;
                        r_tx_state <= TX_STOP;
                    end
                    TX_STOP: begin
                        if (r_tx_bit == 4'(STOP_BITS - 1)) begin
                            r_tx_busy  <= 1'b0;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 4'd1;
                        end
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign uart_tx_o = r_tx_line;
    assign tx_busy_o = r_tx_busy;

    // ---------------- receiver ----------------
    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic                 w_rx;
    logic                 w_rx_fall;
    rx_state_t            r_rx_state;
    logic [3:0]           r_rx_cnt;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [DATA_BITS-1:0] r_rx_dat;
    logic                 r_rx_valid;
    logic                 r_rx_ferr;
    logic                 w_rx_mid;
`ifdef UART_PARITY_EN
    logic                 r_rx_par_err;
    logic                 r_rx_perr;
`endif

    assign w_rx      = r_sync[1];
    assign w_rx_fall = r_rx_prev && !w_rx;
    assign w_rx_mid  = w_tick && (r_rx_cnt == 4'd15);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], uart_rx_i};
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_dat     <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_ferr    <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_err <= 1'b0;
            r_rx_perr    <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_perr  <= 1'b0;
`endif
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                // Half-bit confirmation rejects glitches shorter than the start bit centre.
                RX_START: begin
                    if (w_tick) begin
                        if (r_rx_cnt == 4'd7) begin
                            r_rx_cnt   <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    if (w_tick) r_rx_cnt <= r_rx_cnt + 4'd1;
                    if (w_rx_mid) begin
                        case (r_rx_state)
                            RX_DATA: begin
                                r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                                if (r_rx_bit == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                                    r_rx_state <= RX_PARITY;
`else
                                    r_rx_state <= RX_STOP;
`endif
                                end else begin
                                    r_rx_bit <= r_rx_bit + 4'd1;
                                end
                            end
`ifdef UART_PARITY_EN
                            RX_PARITY: begin
                                r_rx_par_err <= w_rx ^ (^r_rx_shift);
                                r_rx_state   <= RX_STOP;
                            end
`endif
                            RX_STOP: begin
                                r_rx_dat   <= r_rx_shift;
                                r_rx_valid <= 1'b1;
                                r_rx_ferr  <= !w_rx;
`ifdef UART_PARITY_EN
                                r_rx_perr  <= r_rx_par_err;
`endif
                                r_rx_state <= RX_IDLE;
                            end
                            default: r_rx_state <= RX_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign rx_dat_o       = r_rx_dat;
    assign rx_valid_o     = r_rx_valid;
    assign rx_frame_err_o = r_rx_ferr;
`ifdef UART_PARITY_EN
    assign rx_parity_err_o = r_rx_perr;
`else
    assign rx_parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX waveform decode, loopback, glitch, framing and reset cases.
// Parity cases are included when UART_PARITY_EN is defined (DATA_BITS=7 then).
`timescale 1ns/1ps
module tb_uart_core;

    localparam int CLK_HZ = 68000000;
    localparam int BAUD   = 115200;
`ifdef UART_PARITY_EN
    localparam int DB = 7;
    localparam int PB = 1;
`else
    localparam int DB = 8;
    localparam int PB = 0;
`endif
    localparam int  SB    = 1;
    localparam int  NB    = 1 + DB + PB + SB;
    localparam real BITP  = real'(CLK_HZ) / real'(BAUD);
    localparam real TICKP = BITP / 16.0;

    logic          sys_clk_i = 1'b0;
    logic          sys_rst_i;
    logic          tx_wr_i;
    logic [DB-1:0] tx_dat_i;
    logic          tx_busy_o;
    logic          uart_tx_o;
    logic          uart_rx_i;
    logic [DB-1:0] rx_dat_o;
    logic          rx_valid_o;
    logic          rx_frame_err_o;
    logic          rx_parity_err_o;

    logic rx_drive;
    logic loopback;
    assign uart_rx_i = loopback ? uart_tx_o : rx_drive;

    uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .sys_clk_i       (sys_clk_i),
        .sys_rst_i       (sys_rst_i),
        .tx_wr_i         (tx_wr_i),
        .tx_dat_i        (tx_dat_i),
        .tx_busy_o       (tx_busy_o),
        .uart_tx_o       (uart_tx_o),
        .uart_rx_i       (uart_rx_i),
        .rx_dat_o        (rx_dat_o),
        .rx_valid_o      (rx_valid_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_parity_err_o (rx_parity_err_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int checks = 0;
    int errors = 0;

    logic [DB+1:0] rxq[$];
    int            nvalid   = 0;
    int            flag_bad = 0;
    logic          fbits [0:15];

    always @(negedge sys_clk_i) begin
        if (rx_valid_o === 1'b1) begin
            rxq.push_back({rx_frame_err_o, rx_parity_err_o, rx_dat_o});
            nvalid++;
        end else if (rx_frame_err_o !== 1'b0 || rx_parity_err_o !== 1'b0) begin
            flag_bad++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame as it should appear on the wire: start, data LSB first, even parity, stop bits.
    task automatic build_frame(input logic [DB-1:0] d, input logic stop0, input logic flip);
        fbits[0] = 1'b0;
        for (int i = 0; i < DB; i++) fbits[1 + i] = d[i];
        if (PB == 1) fbits[1 + DB] = (^d) ^ flip;
        for (int s = 0; s < SB; s++) fbits[1 + DB + PB + s] = (s == 0) ? stop0 : 1'b1;
    endtask

    task automatic tx_frame(input logic [DB-1:0] d);
        logic line[$];
        int   bud, len, lo, hi, idx, bad, runlen, n;
        bit   first;
        bud = 0;
        while (tx_busy_o && bud < 20000) begin @(negedge sys_clk_i); bud++; end
        tx_dat_i = d;
        tx_wr_i  = 1'b1;
        @(negedge sys_clk_i);
        tx_wr_i  = 1'b0;
        tx_dat_i = DB'($urandom);
        check("tx_busy_rise", tx_busy_o, 1);
        check("tx_start_low", uart_tx_o, 0);
        bud = 0;
        while (tx_busy_o && bud < 20000) begin
            line.push_back(uart_tx_o);
            @(negedge sys_clk_i);
            bud++;
        end
        check("tx_busy_fall", tx_busy_o, 0);
        check("tx_idle_high", uart_tx_o, 1);
        len = line.size();
        lo  = int'((NB - 1) * BITP + 15.0 * TICKP) - 2;
        hi  = int'(NB * BITP) + 2;
        check("tx_frame_len_ok", (len >= lo && len <= hi), 1);
        build_frame(d, 1'b1, 1'b0);
        if (len > 0) begin
            for (int i = 0; i < NB; i++) begin
                idx = len - int'((NB - i - 0.5) * BITP);
                if (idx < 0) idx = 0;
                if (idx >= len) idx = len - 1;
                check($sformatf("tx_bit%0d_of_%0h", i, d), line[idx], fbits[i]);
            end
            bad = 0; runlen = 1; first = 1;
            for (int k = 1; k <= len; k++) begin
                if (k == len || line[k] !== line[k-1]) begin
                    if (!first) begin
                        n = int'(runlen / BITP);
                        if (n < 1) n = 1;
                        if (runlen < int'(n * BITP) - 1 || runlen > int'(n * BITP) + 1) bad++;
                    end
                    first = 0; runlen = 1;
                end else begin
                    runlen++;
                end
            end
            check("tx_bit_widths_bad", bad, 0);
        end
    endtask

    task automatic rx_send(input logic [DB-1:0] d, input logic stop0, input logic flip);
        int c;
        build_frame(d, stop0, flip);
        c = 0;
        for (int i = 0; i < NB; i++) begin
            rx_drive = fbits[i];
            while (c < int'((i + 1) * BITP)) begin @(negedge sys_clk_i); c++; end
        end
        rx_drive = 1'b1;
        repeat (600) @(negedge sys_clk_i);
    endtask

    task automatic expect_rx(input logic [DB-1:0] d, input logic fe, input logic pe);
        logic [DB+1:0] e;
        int bud;
        bud = 0;
        while (rxq.size() == 0 && bud < 3000) begin @(negedge sys_clk_i); bud++; end
        check("rx_frame_received", (rxq.size() > 0), 1);
        if (rxq.size() > 0) begin
            e = rxq.pop_front();
            check("rx_data", e[DB-1:0], d);
            check("rx_frame_err", e[DB+1], fe);
            check("rx_parity_err", e[DB], pe);
        end
    endtask

    initial begin
        logic [DB-1:0] lb [0:4];
        logic [DB-1:0] d;
        int n0;

        sys_rst_i = 1'b1;
        tx_wr_i   = 1'b0;
        tx_dat_i  = '0;
        rx_drive  = 1'b1;
        loopback  = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        check("rst_uart_tx", uart_tx_o, 1);
        check("rst_tx_busy", tx_busy_o, 0);
        check("rst_rx_dat", rx_dat_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_frame_err", rx_frame_err_o, 0);
        check("rst_parity_err", rx_parity_err_o, 0);
        sys_rst_i = 1'b0;
        repeat (5) @(negedge sys_clk_i);

        tx_frame(DB'(8'hA5));

        // Loopback, back-to-back frames including the all-zero and all-one boundaries.
        loopback = 1'b1;
        lb[0] = '0;
        lb[1] = '1;
        lb[2] = DB'(8'h3C);
        lb[3] = DB'($urandom);
        lb[4] = DB'($urandom);
        for (int i = 0; i < 5; i++) tx_frame(lb[i]);
        for (int i = 0; i < 5; i++) expect_rx(lb[i], 1'b0, 1'b0);
        check("rx_dat_held", rx_dat_o, lb[4]);
        loopback = 1'b0;
        repeat (50) @(negedge sys_clk_i);

        n0 = nvalid;
        rx_drive = 1'b0;
        repeat (250) @(negedge sys_clk_i);
        rx_drive = 1'b1;
        repeat (1500) @(negedge sys_clk_i);
        check("glitch_no_valid", nvalid, n0);
        d = DB'($urandom);
        rx_send(d, 1'b1, 1'b0);
        expect_rx(d, 1'b0, 1'b0);

        rx_send(DB'(8'h55), 1'b0, 1'b0);
        expect_rx(DB'(8'h55), 1'b1, 1'b0);
        d = DB'($urandom);
        rx_send(d, 1'b1, 1'b0);
        expect_rx(d, 1'b0, 1'b0);

`ifdef UART_PARITY_EN
        rx_send(DB'(8'h07), 1'b1, 1'b1);
        expect_rx(DB'(8'h07), 1'b0, 1'b1);
        rx_send(DB'(8'h07), 1'b1, 1'b0);
        expect_rx(DB'(8'h07), 1'b0, 1'b0);
`endif

        tx_dat_i = DB'($urandom);
        tx_wr_i  = 1'b1;
        @(negedge sys_clk_i);
        tx_wr_i  = 1'b0;
        repeat (2000) @(negedge sys_clk_i);
        check("midframe_busy", tx_busy_o, 1);
        sys_rst_i = 1'b1;
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        check("abort_tx_high", uart_tx_o, 1);
        check("abort_busy_low", tx_busy_o, 0);
        check("abort_rx_dat", rx_dat_o, 0);
        repeat (20) @(negedge sys_clk_i);
        tx_frame(DB'($urandom));

        check("err_flags_outside_valid", flag_bad, 0);
        check("no_extra_rx_frames", rxq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
